// File: rtl/mac_engine_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_engine_core
// Brief    : Signed multiply / multiply-accumulate stage with a job FSM,
//            a product register and a single-entry shifted output register.
// Revision : 1.0 - initial release
// ============================================================================
module mac_engine_core #(
    parameter int DW_IN  = 32,
    parameter int DW_OUT = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic              simple_mul_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [5:0]        shift_i,
    input  logic              a_valid_i,
    input  logic [DW_IN-1:0]  a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DW_IN-1:0]  b_data_i,
    output logic              b_ready_o,
    output logic              c_valid_o,
    output logic [DW_OUT-1:0] c_data_o,
    input  logic              c_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [CNT_W-1:0]    r_len;
    logic                r_simple;
    logic [5:0]          r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [DW_OUT-1:0]   r_acc;
    logic                r_s1_valid;
    logic [DW_OUT-1:0]   r_s1_prod;
    logic                r_fin_pending;
    logic                r_c_valid;
    logic [DW_OUT-1:0]   r_c_data;

    logic [DW_OUT-1:0]        w_a_ext;
    logic [DW_OUT-1:0]        w_b_ext;
    logic [DW_OUT-1:0]        w_prod;
    logic signed [DW_OUT-1:0] w_prod_sh;
    logic signed [DW_OUT-1:0] w_acc_sh;
    logic                     w_start;
    logic                     w_out_free;
    logic                     w_s1_drain;
    logic                     w_s1_accept;
    logic                     w_ready;
    logic                     w_fire;
    logic                     w_last_fire;
    logic                     w_acc_last;
    logic                     w_out_load;
    logic                     w_flush_done;

    // Sign-extend to full width so the low DW_OUT bits of the product are the signed result
    assign w_a_ext   = {{(DW_OUT-DW_IN){a_data_i[DW_IN-1]}}, a_data_i};
    assign w_b_ext   = {{(DW_OUT-DW_IN){b_data_i[DW_IN-1]}}, b_data_i};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_prod_sh = $signed(r_s1_prod) >>> r_shift;
    assign w_acc_sh  = $signed(r_acc) >>> r_shift;

    assign w_start     = start_i && (len_i != '0);
    assign w_out_free  = !r_c_valid || c_ready_i;
    // In accumulate mode the product stage never waits on the output register
    assign w_s1_drain  = r_s1_valid && (!r_simple || w_out_free);
    assign w_s1_accept = !r_s1_valid || w_s1_drain;
    assign w_ready     = (r_state == S_RUN) && enable_i && (r_cnt < r_len) && w_s1_accept;
    assign w_fire      = w_ready && a_valid_i && b_valid_i;
    assign w_last_fire = w_fire && ((r_cnt + c_cnt_one) == r_len);
    // Only the final product is still in stage1 once the job has entered FLUSH
    assign w_acc_last  = w_s1_drain && !r_simple && (r_state == S_FLUSH);
    assign w_out_load  = r_simple ? w_s1_drain : (r_fin_pending && w_out_free);
    assign w_flush_done = !r_s1_valid && !r_fin_pending && w_out_free;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)      w_state_next = S_RUN;
            S_RUN:   if (w_last_fire)  w_state_next = S_FLUSH;
            S_FLUSH: if (w_flush_done) w_state_next = S_DONE;
            S_DONE:                    w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_simple      <= 1'b0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_prod     <= '0;
            r_fin_pending <= 1'b0;
            r_c_valid     <= 1'b0;
            r_c_data      <= '0;
        end else if (enable_i) begin
            r_state <= w_state_next;

            if ((r_state == S_IDLE) && w_start) begin
                r_len    <= len_i;
                r_simple <= simple_mul_i;
                r_shift  <= shift_i;
                r_cnt    <= '0;
                r_acc    <= '0;
            end

            if (w_fire) begin
                r_cnt      <= r_cnt + c_cnt_one;
                r_s1_valid <= 1'b1;
                r_s1_prod  <= w_prod;
            end else if (w_s1_drain) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_drain && !r_simple) begin
                r_acc <= r_acc + r_s1_prod;
            end

            if (w_acc_last) begin
                r_fin_pending <= 1'b1;
            end else if (w_out_load) begin
                r_fin_pending <= 1'b0;
            end

            // Accept and refill in the same cycle keeps the output stream bubble-free
            if (w_out_load) begin
                r_c_valid <= 1'b1;
                r_c_data  <= r_simple ? w_prod_sh : w_acc_sh;
            end else if (c_ready_i) begin
                r_c_valid <= 1'b0;
            end
        end
    end

    assign a_ready_o = w_ready;
    assign b_ready_o = w_ready;
    assign c_valid_o = r_c_valid;
    assign c_data_o  = r_c_data;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_DONE);
    assign cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_engine_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_engine_core
// Brief    : Directed and randomized jobs against a queue-based arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_engine_core;

    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, enable_i, start_i, simple_mul_i;
    logic [15:0] len_i;
    logic [5:0]  shift_i;
    logic        a_valid_i, b_valid_i, a_ready_o, b_ready_o;
    logic [31:0] a_data_i, b_data_i;
    logic        c_valid_o, c_ready_i, busy_o, done_o;
    logic [63:0] c_data_o;
    logic [15:0] cnt_o;

    int n_pass = 0, n_fail = 0, n_total = 0;
    int cycnt = 0, done_cnt = 0, done_cyc = 0, first_fire_cyc = 0;
    int pa[$], pb[$];
    logic [63:0] res_q[$], exp_q[$];
    int res_cyc[$];
    logic prev_hold = 1'b0;
    logic [63:0] prev_data = '0;

    mac_engine_core #(.DW_IN(32), .DW_OUT(64), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .start_i(start_i), .simple_mul_i(simple_mul_i), .len_i(len_i), .shift_i(shift_i),
        .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .c_valid_o(c_valid_o), .c_data_o(c_data_o), .c_ready_i(c_ready_i),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycnt <= cycnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: collects accepted results, counts done pulses, checks hold stability
    always @(negedge clk_i) begin
        if (prev_hold) begin
            check("c_hold_valid", {63'd0, c_valid_o}, 64'd1);
            check("c_hold_data", c_data_o, prev_data);
        end
        prev_hold <= c_valid_o && !(c_ready_i && enable_i) && !rst_i && !clear_i;
        prev_data <= c_data_o;
        if (!rst_i && !clear_i && enable_i) begin
            if (c_valid_o && c_ready_i) begin
                res_q.push_back(c_data_o);
                res_cyc.push_back(cycnt);
            end
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cycnt;
            end
        end
    end

    // Reference: each product is the exact signed 64-bit value; sums wrap modulo 2^64
    function automatic void build_exp(input bit simple, input int len, input int sh);
        longint sum = 0;
        longint p;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            p = longint'(pa[i]) * longint'(pb[i]);
            if (simple) exp_q.push_back(p >>> sh);
            else        sum += p;
        end
        if (!simple) exp_q.push_back(sum >>> sh);
    endfunction

    task automatic run_job(input bit simple, input int len, input int sh, input int vprob,
                           input int rprob, input int hold, input int enprob,
                           input bit restart, input string tag);
        int  idx, cyc, d0;
        bit  fire;
        idx = 0; cyc = 0; d0 = done_cnt;
        res_q.delete(); res_cyc.delete();
        build_exp(simple, len, sh);
        a_valid_i = 0; b_valid_i = 0;
        start_i = 1; simple_mul_i = simple; len_i = 16'(len); shift_i = 6'(sh);
        @(posedge clk_i); #1;
        start_i = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            start_i = 0;
            if (restart && cyc == 1) begin
                start_i = 1; len_i = 16'd7; simple_mul_i = !simple; shift_i = 6'd5;
            end
            enable_i  = ($urandom_range(99) >= enprob);
            a_valid_i = (idx < len) && ($urandom_range(99) < vprob);
            b_valid_i = (idx < len) && ($urandom_range(99) < vprob);
            a_data_i  = (idx < len) ? pa[idx] : $urandom;
            b_data_i  = (idx < len) ? pb[idx] : $urandom;
            c_ready_i = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rprob);
            @(negedge clk_i);
            fire = a_valid_i && a_ready_o && b_valid_i && b_ready_o;
            if (!enable_i) check({tag, "_ready_disabled"}, {62'd0, a_ready_o, b_ready_o}, 64'd0);
            if (hold > 0 && cyc == hold - 1) check({tag, "_bp_ready_drop"}, {63'd0, a_ready_o}, 64'd0);
            if (fire && idx == 0) first_fire_cyc = cycnt;
            @(posedge clk_i); #1;
            if (fire) idx++;
            cyc++;
        end
        start_i = 0; enable_i = 1; a_valid_i = 0; b_valid_i = 0; c_ready_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_busy_after"}, {63'd0, busy_o}, 64'd0);
        check({tag, "_cnt"}, {48'd0, cnt_o}, len);
        check({tag, "_consumed"}, idx, len);
        check({tag, "_nres"}, res_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < res_q.size(); i++)
            check($sformatf("%s_res%0d", tag, i), res_q[i], exp_q[i]);
    endtask

    initial begin
        int d0;
        rst_i = 1; clear_i = 0; enable_i = 1; start_i = 0; simple_mul_i = 0;
        len_i = 0; shift_i = 0; a_valid_i = 0; b_valid_i = 0;
        a_data_i = 0; b_data_i = 0; c_ready_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_c_valid", {63'd0, c_valid_o}, 64'd0);
        check("rst_c_data", c_data_o, 64'd0);
        check("rst_ready", {62'd0, a_ready_o, b_ready_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_cnt", {48'd0, cnt_o}, 64'd0);
        rst_i = 0;
        @(posedge clk_i); #1;

        // Simple mode, back-to-back pairs
        pa = '{2, -4, 7}; pb = '{3, 5, -1};
        run_job(1, 3, 0, 100, 100, 0, 0, 0, "simple3");
        check("simple3_latency", res_cyc[0] - first_fire_cyc, 2);
        check("simple3_consecutive", res_cyc[2] - res_cyc[0], 2);
        check("simple3_v0", res_q[0], 64'd6);

        // Accumulate mode with shift
        pa = '{1, 2, 3, 4}; pb = '{1, 2, 3, 4};
        run_job(0, 4, 1, 100, 100, 0, 0, 0, "acc4");
        check("acc4_value", res_q[0], 64'd15);
        check("acc4_done_after_c", {63'd0, done_cyc > res_cyc[0]}, 64'd1);

        // Backpressure: output stalled for 5 cycles
        pa = '{10, -11, 12, -13}; pb = '{3, 3, -3, -3};
        run_job(1, 4, 0, 100, 100, 5, 0, 0, "bp4");

        // Handshake skew: lone a_valid is not consumed
        res_q.delete(); d0 = done_cnt;
        start_i = 1; simple_mul_i = 1; len_i = 16'd1; shift_i = 6'd0;
        @(posedge clk_i); #1;
        start_i = 0; a_valid_i = 1; a_data_i = 32'd9; b_valid_i = 0; b_data_i = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check("skew_cnt_hold", {48'd0, cnt_o}, 64'd0);
        check("skew_ready_indep", {63'd0, a_ready_o}, 64'd1);
        b_valid_i = 1; b_data_i = -32'sd3;
        @(posedge clk_i); #1;
        check("skew_cnt_fire", {48'd0, cnt_o}, 64'd1);
        a_valid_i = 0; b_valid_i = 0;
        for (int k = 0; k < 20 && done_cnt == d0; k++) begin
            @(posedge clk_i); #1;
        end
        repeat (2) @(posedge clk_i);
        #1;
        check("skew_done", done_cnt - d0, 1);
        check("skew_nres", res_q.size(), 1);
        check("skew_value", res_q[0], longint'(-27));

        // Accumulator wrap and full-width arithmetic shift
        pa = '{32'h7FFF_FFFF, 32'h7FFF_FFFF}; pb = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_job(0, 2, 0, 100, 100, 0, 0, 0, "wrap");
        check("wrap_value", res_q[0], 64'h7FFF_FFFE_0000_0002);
        pa = '{-1}; pb = '{5};
        run_job(1, 1, 63, 100, 100, 0, 0, 0, "shift63");
        check("shift63_value", res_q[0], 64'hFFFF_FFFF_FFFF_FFFF);

        // Abort by clear after 2 of 5 pairs
        res_q.delete(); d0 = done_cnt;
        start_i = 1; simple_mul_i = 1; len_i = 16'd5; shift_i = 6'd0;
        @(posedge clk_i); #1;
        start_i = 0; a_valid_i = 1; b_valid_i = 1; a_data_i = 32'd4; b_data_i = 32'd6;
        repeat (2) @(posedge clk_i);
        #1;
        a_valid_i = 0; b_valid_i = 0; c_ready_i = 0; clear_i = 1;
        @(posedge clk_i); #1;
        clear_i = 0; c_ready_i = 1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_cnt", {48'd0, cnt_o}, 64'd0);
        check("abort_c_valid", {63'd0, c_valid_o}, 64'd0);
        repeat (5) @(posedge clk_i);
        #1;
        check("abort_no_result", res_q.size(), 0);
        check("abort_no_done", done_cnt - d0, 0);

        // Zero-length start is ignored
        start_i = 1; len_i = 16'd0;
        @(posedge clk_i); #1;
        start_i = 0;
        check("len0_busy", {63'd0, busy_o}, 64'd0);
        @(posedge clk_i); #1;
        check("len0_busy_later", {63'd0, busy_o}, 64'd0);

        // Start during RUN is ignored
        pa = '{3, -8}; pb = '{-7, 2};
        run_job(1, 2, 0, 100, 100, 0, 0, 1, "restart");

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            bit sm;
            int ln, sh;
            sm = $urandom_range(1);
            ln = $urandom_range(1, 8);
            sh = ($urandom_range(3) == 0) ? $urandom_range(63) : 0;
            pa.delete(); pb.delete();
            for (int i = 0; i < ln; i++) begin
                pa.push_back($urandom_range(1) ? int'($urandom) : int'($urandom_range(40)) - 20);
                pb.push_back($urandom_range(1) ? int'($urandom) : int'($urandom_range(40)) - 20);
            end
            run_job(sm, ln, sh, $urandom_range(40, 100), $urandom_range(30, 100), 0, 10, 0,
                    $sformatf("rnd%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
